// File: rtl/debounce_sync_if.sv
// Bundle of the conditioned-input signals between a stimulus source and debounce_sync.
// The raw input and enable flow in; the debounced level and its edge strobes flow out.
interface debounce_sync_if;
    logic i_din;
    logic i_en;
    logic o_dout;
    logic o_rise;
    logic o_fall;

    modport master (
        output i_din,
        output i_en,
        input  o_dout,
        input  o_rise,
        input  o_fall
    );

    modport slave (
        input  i_din,
        input  i_en,
        output o_dout,
        output o_rise,
        output o_fall
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises an asynchronous, bouncing input, filters it with a stability counter
// and emits a clean registered level plus one-cycle rise/fall strobes.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    debounce_sync_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES) + 32'sd1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'sd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic SINGLE_CYCLE = (STABLE_CYCLES == 32'sd1);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_RISING  = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_FALLING = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;

    // Synchroniser chain: shifts every cycle, independent of the enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_din};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Filter next-state: a reverting input on the final count still rejects the change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (bus.i_en) begin
            case (r_state)
                ST_LOW: begin
                    if (w_s && SINGLE_CYCLE) begin
                        w_state_nxt = ST_HIGH;
                        w_rise_nxt  = 1'b1;
                    end else if (w_s) begin
                        w_state_nxt = ST_RISING;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_LOW;
                    end
                end
                ST_RISING: begin
                    if (!w_s) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = CNT_ZERO;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s && SINGLE_CYCLE) begin
                        w_state_nxt = ST_LOW;
                        w_fall_nxt  = 1'b1;
                    end else if (!w_s) begin
                        w_state_nxt = ST_FALLING;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_FALLING: begin
                    if (w_s) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = CNT_ZERO;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Filter state and registered outputs; dout is high in ST_HIGH and ST_FALLING.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_LOW;
            r_cnt   <= CNT_ZERO;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_state_nxt[1];
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign bus.o_dout = r_dout;
    assign bus.o_rise = r_rise;
    assign bus.o_fall = r_fall;
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: two configurations driven in parallel, checked every cycle
// against a run-length model of the filter plus directed literal expectations.
module tb_debounce_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic din = 1'b1;
    logic en  = 1'b1;

    debounce_sync_if bus0 ();
    debounce_sync_if bus1 ();

    assign bus0.i_din = din;
    assign bus0.i_en  = en;
    assign bus1.i_din = din;
    assign bus1.i_en  = en;

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: input delayed by the synchroniser depth; output flips once the delayed
    // input has disagreed with it on STABLE_CYCLES consecutive enabled edges.
    logic mq [2][3];
    int   run [2];
    logic md [2];
    logic mr [2];
    logic mf [2];
    logic ms;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ns;
            int sc;
            ns = (i == 0) ? 2 : 3;
            sc = (i == 0) ? 4 : 1;
            if (rst) begin
                for (int j = 0; j < 3; j++) mq[i][j] = 1'b0;
                run[i] = 0;
                md[i]  = 1'b0;
                mr[i]  = 1'b0;
                mf[i]  = 1'b0;
            end else begin
                ms = mq[i][ns-1];
                for (int j = ns - 1; j > 0; j--) mq[i][j] = mq[i][j-1];
                mq[i][0] = din;
                mr[i] = 1'b0;
                mf[i] = 1'b0;
                if (en) begin
                    if (ms != md[i]) begin
                        run[i]++;
                        if (run[i] == sc) begin
                            md[i]  = ms;
                            mr[i]  = ms;
                            mf[i]  = ~ms;
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
        end
        if (rst) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_dout0", bus0.o_dout, md[0]);
            chk("model_rise0", bus0.o_rise, mr[0]);
            chk("model_fall0", bus0.o_fall, mf[0]);
            chk("model_dout1", bus1.o_dout, md[1]);
            chk("model_rise1", bus1.o_rise, mr[1]);
            chk("model_fall1", bus1.o_fall, mf[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic v);
        din = v;
        repeat (12) step();
    endtask

    int rises;
    int falls;
    int highs;
    int rise_at;
    int fall_at;
    int hold;

    initial begin
        // Reset held with din=1: outputs stay low, then latency counts from release.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_dout", bus0.o_dout, 1'b0);
            chk("rst_rise", bus0.o_rise, 1'b0);
            chk("rst_fall", bus0.o_fall, 1'b0);
        end
        rst = 1'b0;
        repeat (5) step();
        chk("rel_dout_early", bus0.o_dout, 1'b0);
        step();
        chk("rel_dout", bus0.o_dout, 1'b1);
        chk("rel_rise", bus0.o_rise, 1'b1);
        step();
        chk("rel_rise_end", bus0.o_rise, 1'b0);

        // Rising edge latency for both configurations.
        settle(1'b0);
        din = 1'b1;
        repeat (3) step();
        chk("p6_dout_early", bus1.o_dout, 1'b0);
        step();
        chk("p6_dout", bus1.o_dout, 1'b1);
        chk("p6_rise", bus1.o_rise, 1'b1);
        step();
        chk("rise_dout_early", bus0.o_dout, 1'b0);
        chk("p6_rise_end", bus1.o_rise, 1'b0);
        step();
        chk("rise_dout", bus0.o_dout, 1'b1);
        chk("rise_strobe", bus0.o_rise, 1'b1);
        chk("rise_nofall", bus0.o_fall, 1'b0);
        step();
        chk("rise_strobe_end", bus0.o_rise, 1'b0);

        // Glitch boundary: 3-cycle pulse rejected, 4-cycle pulse accepted.
        settle(1'b0);
        din = 1'b1;
        repeat (3) step();
        din = 1'b0;
        rises = 0; falls = 0; highs = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            rises += int'(bus0.o_rise);
            falls += int'(bus0.o_fall);
            highs += int'(bus0.o_dout);
        end
        chk("glitch3_rises", rises, 0);
        chk("glitch3_falls", falls, 0);
        chk("glitch3_highs", highs, 0);

        din = 1'b1;
        repeat (4) step();
        din = 1'b0;
        rises = 0; falls = 0; rise_at = -1; fall_at = -1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (bus0.o_rise) begin rises++; rise_at = c; end
            if (bus0.o_fall) begin falls++; fall_at = c; end
        end
        chk("pulse4_rises", rises, 1);
        chk("pulse4_falls", falls, 1);
        chk("pulse4_gap", fall_at - rise_at, 4);

        // Enable freeze during a falling check.
        settle(1'b1);
        din = 1'b0;
        repeat (4) step();
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("frz_dout", bus0.o_dout, 1'b1);
            chk("frz_fall", bus0.o_fall, 1'b0);
        end
        en = 1'b1;
        step();
        chk("frz_dout_en1", bus0.o_dout, 1'b1);
        step();
        chk("frz_dout_en2", bus0.o_dout, 1'b0);
        chk("frz_fall_en2", bus0.o_fall, 1'b1);
        step();
        chk("frz_fall_end", bus0.o_fall, 1'b0);

        // Reset in the middle of a rising check.
        settle(1'b0);
        din = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("midrst_dout", bus0.o_dout, 1'b0);
            chk("midrst_rise", bus0.o_rise, 1'b0);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("midrst_wait_dout", bus0.o_dout, 1'b0);
        end
        step();
        chk("midrst_dout_rel", bus0.o_dout, 1'b1);
        chk("midrst_rise_rel", bus0.o_rise, 1'b1);

        // Single-cycle pulses pass through the STABLE_CYCLES=1 instance only.
        settle(1'b0);
        rises = 0; falls = 0; highs = 0;
        for (int p = 0; p < 3; p++) begin
            din = 1'b1;
            step();
            rises += int'(bus1.o_rise);
            falls += int'(bus1.o_fall);
            highs += int'(bus0.o_dout);
            din = 1'b0;
            for (int c = 0; c < 3; c++) begin
                step();
                rises += int'(bus1.o_rise);
                falls += int'(bus1.o_fall);
                highs += int'(bus0.o_dout);
            end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            rises += int'(bus1.o_rise);
            falls += int'(bus1.o_fall);
        end
        chk("p6_pulse_rises", rises, 3);
        chk("p6_pulse_falls", falls, 3);
        chk("p6_pulse_dout0", highs, 0);

        // Randomised bouncing input with occasional enable drops and resets.
        hold = 1;
        for (int c = 0; c < 4000; c++) begin
            hold--;
            if (hold == 0) begin
                din  = ~din;
                hold = $urandom_range(1, 7);
            end
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        en  = 1'b1;
        settle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
